ctrl_pipe: RTL and testbench
============================

# ctrl_pipe

Parametrised control-signal pipeline for the in-order RISC-V cores: takes the decoded control bundle at Decode and carries it through DEPTH register stages (default E, B, M, W) with per-stage stall and flush. Branches and jumps resolve at a configurable stage, which drives PC-source selection and automatic flushing of younger stages. Adds stall/bubble handling, valid tracking and branch performance counters, none of which the fixed 5-stage control register chain has.

## Interface
- CTRL_W, 24, width of the opaque control bundle (ALUControl, ResultSrc, MemWrite, RegWrite, ByteSrc, ...)
- DEPTH, 4, number of register stages after Decode; stage 0 = E, DEPTH-1 = W
- RES_STG, 1, stage index where branches resolve (1 = B); legal range 0..DEPTH-2
- CNT_W, 16, width of performance counters
- clk  in  1  clock; single clock domain
- reset  in  1  synchronous, active-high
- ctrl_d  in  CTRL_W  decoded control bundle
- valid_d  in  1  Decode holds a real instruction
- branch_d, jump_d, pred_taken_d  in  1 each  branch/jump flags and predictor decision at Decode
- stall  in  DEPTH  per-stage stall request
- flush  in  DEPTH  per-stage external flush request
- cond_r  in  1  branch condition result at stage RES_STG (ZeroB equivalent)
- ctrl_o  out  DEPTH*CTRL_W  stage k bundle in bits [k*CTRL_W +: CTRL_W]
- valid_o  out  DEPTH  per-stage valid
- hold_d_o  out  1  Decode and Fetch must hold
- flush_fe_o  out  1  Fetch/Decode registers must be flushed (redirect)
- pc_src_o  out  3  PC source select (package enum)
- branches_o, mispred_o  out  CNT_W each  resolved-branch and misprediction counts

## Operation
- Each stage holds {ctrl, valid, branch, jump, pred}. Bubble = all fields zero, so RegWrite/MemWrite are low.
- Effective hold: hold[k] = OR of stall[j] for j >= k. hold_d_o = hold[0].
- Stage k per edge, in priority order:
  - kill[k]: load bubble.
  - hold[k]: keep contents.
  - otherwise: load stage k-1, or Decode inputs for k = 0.
- If hold[k] and not hold[k+1], stage k+1 loads a bubble.
- kill[k] = flush[k] OR (redirect AND k <= RES_STG). Kill overrides hold.
- Resolution at stage R = RES_STG, only when valid_o[R] and not hold[R]:
  - Branch with cond_r != pred → redirect.
  - Jump with pred = 0 → redirect.
  - A valid branch is counted in branches_o; a redirect on a branch is counted in mispred_o.
  - Counters wrap.
- Redirect asserts flush_fe_o. The resolving instruction itself still advances into stage R+1.
- pc_src_o priority:
  - Redirect, actual taken → RESOLVED_TGT (2).
  - Redirect, actual not taken → RECOVER_SEQ (3).
  - Else valid_d and pred_taken_d and not hold[0] → PRED_TGT (1).
  - Else SEQ (0).
- Simultaneous external flush and redirect: the union of kills applies.

## Timing
- Reset: all stages, counters and registered state are zero. Outputs: ctrl_o = 0, valid_o = 0, pc_src_o = SEQ, flush_fe_o = 0, hold_d_o = stall-driven only.
- Latency: Decode → stage k output = k+1 cycles when no stalls occur.
- Redirect, pc_src_o, flush_fe_o and hold_d_o are combinational from the current stage state and inputs. All stage updates happen on the rising edge.
- Reset mid-stall or mid-redirect: the next edge yields the reset state with no residual flush.
- A held stage at RES_STG does not resolve. It resolves exactly once, in the cycle it advances.
- A branch bubbled by flush is never counted.

## Structure
- Package ctrl_pipe_pkg holds:
  - pc_src_e: SEQ = 0, PRED_TGT = 1, RESOLVED_TGT = 2, RECOVER_SEQ = 3.
  - Default CTRL_W.
  - Bundle field offset constants shared with the decoder.
- Sub-module ctrl_pipe_stage: one register stage with in/out payload, hold and kill. Instantiated DEPTH times via generate.
- The top level holds the hold/kill derivation, the resolution logic, pc_src and the counters.

## Test plan
Defaults apply: DEPTH = 4, RES_STG = 1.
- **Straight flow:** feed ctrl_d = 0x000001..0x000005 on consecutive cycles with valid_d = 1 → 0x000001 appears on stage 3 four cycles later, in order; valid_o = 4'b1111 at steady state.
- **Stall:** stall = 4'b0100 for 2 cycles → stages 0–2 frozen, hold_d_o = 1, stage 3 receives a bubble (valid_o[3] = 0, ctrl = 0) for 2 cycles, then flow resumes with no loss or duplication.
- **Mispredicted branch:** branch with pred = 0 reaches stage 1 with cond_r = 1 → pc_src_o = 2, flush_fe_o = 1; next edge valid_o[1:0] = 0, the branch is in stage 2; branches_o = 1, mispred_o = 1.
- **Predicted-taken false:** pred = 1 and cond_r = 0 → pc_src_o = 3; correct prediction (pred = 1, cond_r = 1) → no redirect and mispred_o unchanged.
- **Flush priority and reset:** flush = 4'b0001 together with stall = 4'b0001 → stage 0 becomes a bubble. Reset asserted mid-redirect → all outputs zero and counters zero on the next edge.

Source files
------------

// File: rtl/ctrl_pipe_pkg.sv
// Shared types and constants for the control-signal pipeline and the decoder
// that builds the control bundle it carries.
package ctrl_pipe_pkg;

  localparam int CTRL_W_DEF = 24;

  // Field offsets inside the opaque control bundle, kept in sync with the decoder
  localparam int CTRL_REGWRITE     = 0;
  localparam int CTRL_MEMWRITE     = 1;
  localparam int CTRL_RESSRC_LSB   = 2;
  localparam int CTRL_RESSRC_W     = 2;
  localparam int CTRL_ALUCTL_LSB   = 4;
  localparam int CTRL_ALUCTL_W     = 4;
  localparam int CTRL_BYTESRC_LSB  = 8;
  localparam int CTRL_BYTESRC_W    = 2;

  // Per-stage metadata stored above the bundle: {pred, jump, branch, valid}
  localparam int META_VALID  = 0;
  localparam int META_BRANCH = 1;
  localparam int META_JUMP   = 2;
  localparam int META_PRED   = 3;
  localparam int META_W      = 4;

  typedef enum logic [2:0] {
    SEQ          = 3'd0,
    PRED_TGT     = 3'd1,
    RESOLVED_TGT = 3'd2,
    RECOVER_SEQ  = 3'd3
  } pc_src_e;

endpackage

// File: rtl/ctrl_pipe_stage.sv
// One pipeline register stage: kill beats hold, hold beats load.
module ctrl_pipe_stage
  import ctrl_pipe_pkg::*;
#(
  parameter int W = CTRL_W_DEF + META_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         hold_i,
  input  logic         kill_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] data_o
);

  logic [W-1:0] data_q;
  logic [W-1:0] data_d;

  always_comb begin
    data_d = data_i;
    if (kill_i) begin
      data_d = '0;
    end else if (hold_i) begin
      data_d = data_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/ctrl_pipe.sv
// Control-signal pipeline from Decode through DEPTH stages with stall, flush,
// branch resolution at RES_STG, PC-source selection and branch counters.
module ctrl_pipe
  import ctrl_pipe_pkg::*;
#(
  parameter int CTRL_W  = CTRL_W_DEF,
  parameter int DEPTH   = 4,
  parameter int RES_STG = 1,
  parameter int CNT_W   = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [CTRL_W-1:0]       ctrl_d,
  input  logic                    valid_d,
  input  logic                    branch_d,
  input  logic                    jump_d,
  input  logic                    pred_taken_d,
  input  logic [DEPTH-1:0]        stall,
  input  logic [DEPTH-1:0]        flush,
  input  logic                    cond_r,
  output logic [DEPTH*CTRL_W-1:0] ctrl_o,
  output logic [DEPTH-1:0]        valid_o,
  output logic                    hold_d_o,
  output logic                    flush_fe_o,
  output logic [2:0]              pc_src_o,
  output logic [CNT_W-1:0]        branches_o,
  output logic [CNT_W-1:0]        mispred_o
);

  localparam int PW       = CTRL_W + META_W;
  localparam int VALID_B  = CTRL_W + META_VALID;
  localparam int BRANCH_B = CTRL_W + META_BRANCH;
  localparam int JUMP_B   = CTRL_W + META_JUMP;
  localparam int PRED_B   = CTRL_W + META_PRED;

  logic [DEPTH-1:0] holdVec;
  logic [DEPTH-1:0] killVec;
  logic [PW-1:0]    stageIn  [DEPTH];
  logic [PW-1:0]    stageOut [DEPTH];

  logic    resValid;
  logic    resBranch;
  logic    resJump;
  logic    resPred;
  logic    redirect;
  logic    actualTaken;
  pc_src_e pcSrc;

  logic [CNT_W-1:0] branchCnt_q, branchCnt_d;
  logic [CNT_W-1:0] mispredCnt_q, mispredCnt_d;

  // A stall anywhere downstream freezes every older stage as well
  always_comb begin
    holdVec = '0;
    holdVec[DEPTH-1] = stall[DEPTH-1];
    for (int k = DEPTH - 2; k >= 0; k--) begin
      holdVec[k] = stall[k] | holdVec[k+1];
    end
  end

  always_comb begin
    killVec = '0;
    for (int k = 0; k < DEPTH; k++) begin
      killVec[k] = flush[k] | (redirect & (k <= RES_STG));
    end
  end

  assign stageIn[0] = {pred_taken_d, jump_d, branch_d, valid_d, ctrl_d};

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    if (k > 0) begin : g_link
      // The stage just past the held boundary receives a bubble
      assign stageIn[k] = holdVec[k-1] ? '0 : stageOut[k-1];
    end

    ctrl_pipe_stage #(
      .W(PW)
    ) u_stage (
      .clk    (clk),
      .reset  (reset),
      .hold_i (holdVec[k]),
      .kill_i (killVec[k]),
      .data_i (stageIn[k]),
      .data_o (stageOut[k])
    );

    assign ctrl_o[k*CTRL_W +: CTRL_W] = stageOut[k][CTRL_W-1:0];
    assign valid_o[k]                 = stageOut[k][VALID_B];
  end

  // A held instruction at the resolve stage waits until the cycle it advances
  assign resValid  = stageOut[RES_STG][VALID_B] & ~holdVec[RES_STG];
  assign resBranch = stageOut[RES_STG][BRANCH_B];
  assign resJump   = stageOut[RES_STG][JUMP_B];
  assign resPred   = stageOut[RES_STG][PRED_B];

  always_comb begin
    redirect    = 1'b0;
    actualTaken = resJump | cond_r;
    if (resValid) begin
      if (resJump) begin
        redirect = ~resPred;
      end else if (resBranch) begin
        redirect = (cond_r != resPred);
      end
    end
  end

  always_comb begin
    pcSrc = SEQ;
    if (redirect) begin
      pcSrc = actualTaken ? RESOLVED_TGT : RECOVER_SEQ;
    end else if (valid_d && pred_taken_d && !holdVec[0]) begin
      pcSrc = PRED_TGT;
    end
  end

  always_comb begin
    branchCnt_d  = branchCnt_q;
    mispredCnt_d = mispredCnt_q;
    if (resValid && resBranch && !resJump) begin
      branchCnt_d = branchCnt_q + CNT_W'(1);
      if (cond_r != resPred) begin
        mispredCnt_d = mispredCnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      branchCnt_q  <= '0;
      mispredCnt_q <= '0;
    end else begin
      branchCnt_q  <= branchCnt_d;
      mispredCnt_q <= mispredCnt_d;
    end
  end

  assign hold_d_o   = holdVec[0];
  assign flush_fe_o = redirect;
  assign pc_src_o   = pcSrc;
  assign branches_o = branchCnt_q;
  assign mispred_o  = mispredCnt_q;

  // Branch metadata of the last stage has no consumer
  logic unusedLastMeta;
  assign unusedLastMeta = ^stageOut[DEPTH-1][PRED_B:BRANCH_B];

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed self-checking bench for ctrl_pipe with default parameters
// (DEPTH = 4, resolve at stage 1).
module tb_ctrl_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] ctrl_d;
  logic        valid_d, branch_d, jump_d, pred_taken_d;
  logic [3:0]  stall, flush;
  logic        cond_r;
  logic [95:0] ctrl_o;
  logic [3:0]  valid_o;
  logic        hold_d_o, flush_fe_o;
  logic [2:0]  pc_src_o;
  logic [15:0] branches_o, mispred_o;

  int total = 0;
  int bad   = 0;

  ctrl_pipe dut (
    .clk          (clk),
    .reset        (reset),
    .ctrl_d       (ctrl_d),
    .valid_d      (valid_d),
    .branch_d     (branch_d),
    .jump_d       (jump_d),
    .pred_taken_d (pred_taken_d),
    .stall        (stall),
    .flush        (flush),
    .cond_r       (cond_r),
    .ctrl_o       (ctrl_o),
    .valid_o      (valid_o),
    .hold_d_o     (hold_d_o),
    .flush_fe_o   (flush_fe_o),
    .pc_src_o     (pc_src_o),
    .branches_o   (branches_o),
    .mispred_o    (mispred_o)
  );

  always #5 clk = ~clk;

  function automatic logic [95:0] pack4(input logic [23:0] s3, s2, s1, s0);
    return {s3, s2, s1, s0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    ctrl_d = '0; valid_d = 0; branch_d = 0; jump_d = 0; pred_taken_d = 0;
    stall = '0; flush = '0; cond_r = 0;
  endtask

  task automatic drain();
    set_idle();
    for (int i = 0; i < 4; i++) tick();
  endtask

  // Feed one instruction at Decode and clock it into stage 0
  task automatic issue(input logic [23:0] c, input logic br, input logic jp, input logic pr);
    ctrl_d = c; valid_d = 1; branch_d = br; jump_d = jp; pred_taken_d = pr;
    tick();
    set_idle();
  endtask

  task automatic test_reset();
    reset = 1; set_idle();
    stall = 4'b1000;
    tick(); tick();
    total++; if (ctrl_o !== '0) begin bad++; $display("FAIL reset_ctrl: got %h want 0", ctrl_o); end
    total++; if (valid_o !== 4'b0) begin bad++; $display("FAIL reset_valid: got %b want 0000", valid_o); end
    total++; if (pc_src_o !== 3'd0 || flush_fe_o !== 1'b0) begin bad++; $display("FAIL reset_pc: pc=%0d fl=%b want 0 0", pc_src_o, flush_fe_o); end
    total++; if (branches_o !== 16'd0 || mispred_o !== 16'd0) begin bad++; $display("FAIL reset_cnt: br=%0d mp=%0d want 0 0", branches_o, mispred_o); end
    total++; if (hold_d_o !== 1'b1) begin bad++; $display("FAIL reset_hold: got %b want 1", hold_d_o); end
    stall = '0; #1;
    total++; if (hold_d_o !== 1'b0) begin bad++; $display("FAIL reset_hold_clr: got %b want 0", hold_d_o); end
    reset = 0;
    tick();
  endtask

  task automatic test_straight_flow();
    logic [95:0] expCtrl;
    logic [3:0]  expValid;
    int idx;
    for (int t = 1; t <= 8; t++) begin
      ctrl_d  = (t <= 5) ? 24'(t) : 24'd0;
      valid_d = (t <= 5);
      tick();
      expCtrl = '0; expValid = '0;
      for (int k = 0; k < 4; k++) begin
        idx = t - k;
        if (idx >= 1 && idx <= 5) begin
          expCtrl[k*24 +: 24] = 24'(idx);
          expValid[k] = 1'b1;
        end
      end
      total++; if (ctrl_o !== expCtrl) begin bad++; $display("FAIL flow_ctrl t=%0d: got %h want %h", t, ctrl_o, expCtrl); end
      total++; if (valid_o !== expValid) begin bad++; $display("FAIL flow_valid t=%0d: got %b want %b", t, valid_o, expValid); end
    end
    set_idle();
    tick();
  endtask

  task automatic test_stall();
    for (int i = 1; i <= 4; i++) begin
      ctrl_d = 24'h10 + 24'(i); valid_d = 1; tick();
    end
    total++; if (ctrl_o !== pack4(24'h11, 24'h12, 24'h13, 24'h14)) begin bad++; $display("FAIL stall_fill: got %h", ctrl_o); end
    ctrl_d = 24'h15; valid_d = 1; stall = 4'b0100;
    #1;
    total++; if (hold_d_o !== 1'b1) begin bad++; $display("FAIL stall_hold_d: got %b want 1", hold_d_o); end
    for (int c = 0; c < 2; c++) begin
      tick();
      total++; if (ctrl_o !== pack4(24'h0, 24'h12, 24'h13, 24'h14)) begin bad++; $display("FAIL stall_frozen c=%0d: got %h", c, ctrl_o); end
      total++; if (valid_o !== 4'b0111) begin bad++; $display("FAIL stall_bubble c=%0d: got %b want 0111", c, valid_o); end
    end
    stall = '0;
    tick();
    total++; if (ctrl_o !== pack4(24'h12, 24'h13, 24'h14, 24'h15)) begin bad++; $display("FAIL stall_resume: got %h", ctrl_o); end
    ctrl_d = 24'h16;
    tick();
    total++; if (ctrl_o !== pack4(24'h13, 24'h14, 24'h15, 24'h16) || valid_o !== 4'b1111) begin bad++; $display("FAIL stall_resume2: got %h v=%b", ctrl_o, valid_o); end
    drain();
    total++; if (valid_o !== 4'b0) begin bad++; $display("FAIL stall_drain: got %b want 0000", valid_o); end
  endtask

  task automatic test_mispredict();
    issue(24'hA1, 1, 0, 0);
    issue(24'hB2, 0, 0, 0);
    ctrl_d = 24'hB3; valid_d = 1; cond_r = 1;
    #1;
    total++; if (pc_src_o !== 3'd2 || flush_fe_o !== 1'b1) begin bad++; $display("FAIL misp_redirect: pc=%0d fl=%b want 2 1", pc_src_o, flush_fe_o); end
    tick();
    set_idle(); #1;
    total++; if (valid_o !== 4'b0100 || ctrl_o !== pack4(24'h0, 24'hA1, 24'h0, 24'h0)) begin bad++; $display("FAIL misp_kill: v=%b ctrl=%h", valid_o, ctrl_o); end
    total++; if (branches_o !== 16'd1 || mispred_o !== 16'd1) begin bad++; $display("FAIL misp_cnt: br=%0d mp=%0d want 1 1", branches_o, mispred_o); end
    total++; if (flush_fe_o !== 1'b0) begin bad++; $display("FAIL misp_fl_clr: got %b want 0", flush_fe_o); end
    drain();
  endtask

  task automatic test_predicted_taken();
    ctrl_d = 24'hC1; valid_d = 1; branch_d = 1; pred_taken_d = 1;
    #1;
    total++; if (pc_src_o !== 3'd1) begin bad++; $display("FAIL pred_tgt: got %0d want 1", pc_src_o); end
    tick(); set_idle(); tick();
    cond_r = 0; #1;
    total++; if (pc_src_o !== 3'd3 || flush_fe_o !== 1'b1) begin bad++; $display("FAIL recover_seq: pc=%0d fl=%b want 3 1", pc_src_o, flush_fe_o); end
    tick();
    total++; if (branches_o !== 16'd2 || mispred_o !== 16'd2) begin bad++; $display("FAIL recover_cnt: br=%0d mp=%0d want 2 2", branches_o, mispred_o); end
    issue(24'hC2, 1, 0, 1); tick();
    cond_r = 1; #1;
    total++; if (pc_src_o !== 3'd0 || flush_fe_o !== 1'b0) begin bad++; $display("FAIL correct_pred: pc=%0d fl=%b want 0 0", pc_src_o, flush_fe_o); end
    tick(); cond_r = 0;
    total++; if (branches_o !== 16'd3 || mispred_o !== 16'd2) begin bad++; $display("FAIL correct_cnt: br=%0d mp=%0d want 3 2", branches_o, mispred_o); end
    issue(24'hC3, 0, 1, 0); tick();
    #1;
    total++; if (pc_src_o !== 3'd2 || flush_fe_o !== 1'b1) begin bad++; $display("FAIL jump_redirect: pc=%0d fl=%b want 2 1", pc_src_o, flush_fe_o); end
    tick();
    total++; if (branches_o !== 16'd3 || mispred_o !== 16'd2) begin bad++; $display("FAIL jump_cnt: br=%0d mp=%0d want 3 2", branches_o, mispred_o); end
    drain();
  endtask

  task automatic test_held_resolve();
    issue(24'hD1, 1, 0, 0); tick();
    stall = 4'b0010; cond_r = 1; #1;
    total++; if (flush_fe_o !== 1'b0 || pc_src_o !== 3'd0 || hold_d_o !== 1'b1) begin bad++; $display("FAIL held_nores: fl=%b pc=%0d hold=%b want 0 0 1", flush_fe_o, pc_src_o, hold_d_o); end
    tick();
    total++; if (valid_o !== 4'b0010 || branches_o !== 16'd3) begin bad++; $display("FAIL held_state: v=%b br=%0d want 0010 3", valid_o, branches_o); end
    stall = '0; #1;
    total++; if (flush_fe_o !== 1'b1 || pc_src_o !== 3'd2) begin bad++; $display("FAIL held_release: fl=%b pc=%0d want 1 2", flush_fe_o, pc_src_o); end
    tick();
    total++; if (branches_o !== 16'd4 || mispred_o !== 16'd3 || valid_o !== 4'b0100) begin bad++; $display("FAIL held_once: br=%0d mp=%0d v=%b want 4 3 0100", branches_o, mispred_o, valid_o); end
    drain();
  endtask

  task automatic test_flush_priority();
    issue(24'hE1, 0, 0, 0);
    flush = 4'b0001; stall = 4'b0001; #1;
    total++; if (hold_d_o !== 1'b1) begin bad++; $display("FAIL fp_hold: got %b want 1", hold_d_o); end
    tick();
    total++; if (valid_o !== 4'b0 || ctrl_o !== '0) begin bad++; $display("FAIL fp_bubble: v=%b ctrl=%h want 0", valid_o, ctrl_o); end
    set_idle();
  endtask

  task automatic test_reset_mid_redirect();
    issue(24'hF1, 1, 0, 0); issue(24'hF2, 0, 0, 0);
    cond_r = 1; #1;
    total++; if (flush_fe_o !== 1'b1) begin bad++; $display("FAIL rst_pre: fl=%b want 1", flush_fe_o); end
    reset = 1; stall = 4'b0100;
    tick();
    total++; if (valid_o !== 4'b0 || ctrl_o !== '0 || flush_fe_o !== 1'b0 || pc_src_o !== 3'd0) begin bad++; $display("FAIL rst_state: v=%b fl=%b pc=%0d", valid_o, flush_fe_o, pc_src_o); end
    total++; if (branches_o !== 16'd0 || mispred_o !== 16'd0 || hold_d_o !== 1'b1) begin bad++; $display("FAIL rst_cnt: br=%0d mp=%0d hold=%b want 0 0 1", branches_o, mispred_o, hold_d_o); end
    reset = 0; set_idle(); tick();
  endtask

  initial begin
    set_idle();
    test_reset();
    test_straight_flow();
    test_stall();
    test_mispredict();
    test_predicted_taken();
    test_held_resolve();
    test_flush_priority();
    test_reset_mid_redirect();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
